// File: rtl/display_share_arbiter.sv
// Round-robin arbiter that shares one 7-segment message display between two channels.
// Each grant shows the owner's code for HOLD_TICKS cycles, then the display is blanked for GAP_TICKS cycles.
//
// state | meaning
// IDLE  | display shows H, no owner, waiting for a request
// SHOW  | owner's latched pattern on the display, hold timer running
// GAP   | display blank after a message, new requests not accepted
module display_share_arbiter #(
  parameter int HOLD_TICKS = 8,
  parameter int GAP_TICKS  = 2,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] code0,
  input  logic [2:0] code1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic [7:0] display
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [7:0]       SEG_H     = 8'b01101110;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       grant_d, done_d;
  logic             busy_d, last, last_d, win;
  logic [7:0]       display_d;

  function automatic logic [7:0] seg_of(input logic [2:0] code);
    case (code)
      3'b001:  seg_of = 8'b11101110;
      3'b010:  seg_of = 8'b11111110;
      3'b011:  seg_of = 8'b11001110;
      3'b100:  seg_of = 8'b10011100;
      3'b101:  seg_of = 8'b00000001;
      3'b110:  seg_of = 8'b10111110;
      3'b111:  seg_of = 8'b01101110;
      default: seg_of = 8'b00000000;
    endcase
  endfunction

  // On a tie the channel that was not served last wins.
  assign win = (req == 2'b11) ? ~last : req[1];

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    grant_d   = grant;
    done_d    = 2'b00;
    busy_d    = busy;
    display_d = display;
    last_d    = last;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (req != 2'b00) begin
          state_d   = SHOW;
          grant_d   = win ? 2'b10 : 2'b01;
          display_d = seg_of(win ? code1 : code0);
          busy_d    = 1'b1;
          last_d    = win;
        end
      end
      SHOW: begin
        // A dropped request ends the message early without a done pulse.
        if ((req & grant) == 2'b00) begin
          state_d   = GAP;
          grant_d   = 2'b00;
          display_d = 8'b00000000;
          cnt_d     = '0;
        end else if (cnt == HOLD_LAST) begin
          state_d   = GAP;
          done_d    = grant;
          grant_d   = 2'b00;
          display_d = 8'b00000000;
          cnt_d     = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d   = IDLE;
          display_d = SEG_H;
          busy_d    = 1'b0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = 2'b00;
        busy_d    = 1'b0;
        display_d = SEG_H;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      grant   <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      display <= SEG_H;
      last    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
      display <= display_d;
      last    <= last_d;
    end
  end

endmodule
